// File: rtl/acc_tx_reporter.sv
`default_nettype none
// ============================================================================
// Module   : acc_tx_reporter
// Brief    : Post-halt debug reporter. Counts run cycles, then on CPU halt
//            captures {HEADER, accumulator, cycle count} and streams it MSB
//            first, one byte at a time, through a UART TX start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module acc_tx_reporter #(
    parameter int          DATA_LENGTH  = 16,
    parameter int          COUNT_LENGTH = 16,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   halt,
    input  logic [DATA_LENGTH-1:0] accValue,
    input  logic                   txDone,
    output logic                   txStart,
    output logic [7:0]             txData,
    output logic                   done
);

    localparam int c_FRAME_W   = 8 + DATA_LENGTH + COUNT_LENGTH;
    localparam int c_NUM_BYTES = c_FRAME_W / 8;
    localparam int c_IDX_W     = $clog2(c_NUM_BYTES);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_capture;
    logic                    w_advance;
    logic [c_FRAME_W-1:0]    r_frame;
    logic [c_IDX_W-1:0]      r_idx;
    logic [COUNT_LENGTH-1:0] r_count;

    // State register; reset aborts any frame in progress on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; halt only matters in IDLE, txDone only in WAIT.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (halt) begin
                    w_state_next = S_SEND;
                    w_capture    = 1'b1;
                end
            end
            S_SEND: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (txDone) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_SEND;
                        w_advance    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Frame shift register and byte index: load on capture, shift per byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame <= '0;
            r_idx   <= '0;
        end else if (w_capture) begin
            r_frame <= {HEADER, accValue, r_count};
            r_idx   <= '0;
        end else if (w_advance) begin
            r_frame <= r_frame << 8;
            r_idx   <= r_idx + 1'b1;
        end
    end

    // Saturating run-cycle counter; frozen on the capture edge and afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if ((r_state == S_IDLE) && !halt && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Outputs come straight from registers: no input-to-output paths.
    assign txStart = (r_state == S_SEND);
    assign done    = (r_state == S_DONE);
    assign txData  = r_frame[c_FRAME_W-1 -: 8];

endmodule
`default_nettype wire

// File: tb/tb_acc_tx_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_tx_reporter
// Brief    : Self-checking bench for acc_tx_reporter. Expected frame bytes are
//            queued when halt is driven and popped as each txStart appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_tx_reporter;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic [15:0] accValue;
    logic        txDone;
    logic        txStart;
    logic [7:0]  txData;
    logic        done;

    logic        reset8;
    logic        halt8;
    logic        txStart8;
    logic [7:0]  txData8;
    logic        done8;

    logic        tie;
    logic        pulse;
    bit          resp_en;
    int          resp_dly;

    int          checks   = 0;
    int          failures = 0;
    int          n_tx     = 0;
    int          n_tx8    = 0;
    logic [7:0]  q[$];
    logic [7:0]  q8[$];

    assign txDone = tie | pulse;

    always #5 clk = ~clk;

    acc_tx_reporter #(.DATA_LENGTH(16), .COUNT_LENGTH(16), .HEADER(8'hA5)) u_dut (
        .clk(clk), .reset(reset), .halt(halt), .accValue(accValue),
        .txDone(txDone), .txStart(txStart), .txData(txData), .done(done)
    );

    acc_tx_reporter #(.DATA_LENGTH(16), .COUNT_LENGTH(8), .HEADER(8'hA5)) u_dut8 (
        .clk(clk), .reset(reset8), .halt(halt8), .accValue(accValue),
        .txDone(1'b1), .txStart(txStart8), .txData(txData8), .done(done8)
    );

    typedef struct {
        logic [15:0] acc;
        int          nidle;
        int          dly;
        bit          tie_done;
        bit          freeze;
        logic [39:0] exp_frame;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        check("done_reached", done, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        resp_en  = !v.tie_done;
        resp_dly = v.dly;
        tie      = v.tie_done;
        accValue = v.acc;
        halt     = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        n_tx  = 0;
        repeat (v.nidle) tick();
        for (int b = 4; b >= 0; b--) q.push_back(v.exp_frame[b*8 +: 8]);
        halt = 1'b1;
        tick();
        check("txStart_after_capture", txStart, 1'b1);
        if (v.freeze) begin
            accValue = 16'h0000;
            halt     = 1'b0;
        end
        wait_done(cyc);
        check("tx_count", n_tx, 5);
        check("queue_empty", q.size(), 0);
        if (v.exp_cycles != 0) check("frame_cycles", cyc, v.exp_cycles);
        halt    = 1'b0;
        tie     = 1'b0;
        resp_en = 1'b0;
    endtask

    initial begin
        int cyc;
        bit done_dropped;

        vecs[0] = '{16'h1234, 10, 3, 1'b0, 1'b0, 40'hA5_1234_000A, 0};
        vecs[1] = '{16'hBEEF,  7, 2, 1'b0, 1'b1, 40'hA5_BEEF_0007, 0};
        vecs[2] = '{16'h5A5A,  4, 0, 1'b1, 1'b0, 40'hA5_5A5A_0004, 10};
        vecs[3] = '{16'h00FF,  0, 1, 1'b0, 1'b0, 40'hA5_00FF_0000, 0};
        vecs[4] = '{16'h8001, 25, 5, 1'b0, 1'b0, 40'hA5_8001_0019, 0};

        reset    = 1'b1;
        halt     = 1'b0;
        accValue = 16'h0000;
        reset8   = 1'b1;
        halt8    = 1'b0;
        tie      = 1'b0;
        pulse    = 1'b0;
        resp_en  = 1'b0;
        resp_dly = 1;

        fork
            begin : monitor
                bit prev = 1'b0;
                forever begin
                    @(negedge clk);
                    if (txStart === 1'b1) begin
                        n_tx++;
                        if (prev) fail_now("txStart_consecutive", 1);
                        if (reset === 1'b1) fail_now("txStart_in_reset", 1);
                        if (q.size() == 0) fail_now("txStart_unexpected", txData);
                        else check("tx_byte", txData, q.pop_front());
                    end
                    prev = (txStart === 1'b1);
                end
            end
            begin : monitor8
                forever begin
                    @(negedge clk);
                    if (txStart8 === 1'b1) begin
                        n_tx8++;
                        if (q8.size() == 0) fail_now("txStart8_unexpected", txData8);
                        else check("tx8_byte", txData8, q8.pop_front());
                    end
                end
            end
            begin : responder
                forever begin
                    @(negedge clk);
                    if (resp_en && txStart === 1'b1) begin
                        repeat (resp_dly) @(posedge clk);
                        #1 pulse = 1'b1;
                        @(posedge clk);
                        #1 pulse = 1'b0;
                    end
                end
            end
        join_none

        // Reset state
        tick();
        check("reset_txStart", txStart, 1'b0);
        check("reset_txData", txData, 8'h00);
        check("reset_done", done, 1'b0);

        // Table-driven frames
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset while waiting after the 2nd byte, then a fresh frame
        resp_en  = 1'b1;
        resp_dly = 3;
        accValue = 16'hC3D4;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        n_tx  = 0;
        repeat (5) tick();
        q.push_back(8'hA5);
        q.push_back(8'hC3);
        halt = 1'b1;
        cyc  = 0;
        while (n_tx < 2 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("midreset_two_bytes", n_tx, 2);
        reset = 1'b1;
        halt  = 1'b0;
        check("midreset_wait_txStart", txStart, 1'b0);
        tick();
        check("midreset_txData", txData, 8'h00);
        check("midreset_done", done, 1'b0);
        tick();
        reset = 1'b0;
        check("midreset_queue", q.size(), 0);
        n_tx = 0;
        repeat (3) tick();
        q.push_back(8'hA5);
        q.push_back(8'hC3);
        q.push_back(8'hD4);
        q.push_back(8'h00);
        q.push_back(8'h03);
        halt = 1'b1;
        tick();
        check("midreset_done_early", done, 1'b0);
        wait_done(cyc);
        check("midreset_tx_count", n_tx, 5);
        check("midreset_queue_end", q.size(), 0);
        halt    = 1'b0;
        resp_en = 1'b0;

        // Halt held through reset release; DONE must be sticky
        tie      = 1'b1;
        accValue = 16'h7E81;
        reset    = 1'b1;
        halt     = 1'b1;
        repeat (2) tick();
        q.push_back(8'hA5);
        q.push_back(8'h7E);
        q.push_back(8'h81);
        q.push_back(8'h00);
        q.push_back(8'h00);
        n_tx  = 0;
        reset = 1'b0;
        wait_done(cyc);
        done_dropped = 1'b0;
        for (int i = 0; i < 12; i++) begin
            halt = ~halt;
            tick();
            if (done !== 1'b1) done_dropped = 1'b1;
        end
        check("done_sticky", done_dropped, 1'b0);
        check("no_second_frame", n_tx, 5);
        check("halt_release_queue", q.size(), 0);
        halt = 1'b0;
        tie  = 1'b0;

        // 8-bit counter saturates rather than wrapping
        accValue = 16'h0102;
        tick();
        reset8 = 1'b0;
        repeat (300) tick();
        q8.push_back(8'hA5);
        q8.push_back(8'h01);
        q8.push_back(8'h02);
        q8.push_back(8'hFF);
        halt8 = 1'b1;
        cyc   = 0;
        while (done8 !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("sat_done", done8, 1'b1);
        check("sat_tx_count", n_tx8, 4);
        check("sat_queue", q8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
